// File: rtl/rn_axi_noc_bridge_pkg.sv
// Shared widths, NoC request payload layout, AW tracker entry type and the
// address-to-node (SAM) map used by the RN AXI-to-NoC bridge.
package rn_pkg;

    localparam int RN_ID_W    = 11;
    localparam int RN_ADDR_W  = 32;
    localparam int RN_DATA_W  = 64;
    localparam int RN_NODE_W  = 2;
    localparam int RN_PLD_W   = 82;
    localparam int RN_LEN_W   = 8;
    localparam int RN_SIZE_W  = 3;
    localparam int RN_BURST_W = 2;
    localparam int RN_RESP_W  = 2;
    localparam int RN_BPLD_W  = 20;

    // AW/AR request payload layout, packed upward from bit 0; bits above are zero.
    localparam int OFS_ID    = 0;
    localparam int OFS_ADDR  = OFS_ID + RN_ID_W;
    localparam int OFS_LEN   = OFS_ADDR + RN_ADDR_W;
    localparam int OFS_SIZE  = OFS_LEN + RN_LEN_W;
    localparam int OFS_BURST = OFS_SIZE + RN_SIZE_W;

    typedef struct packed {
        logic [RN_NODE_W-1:0] tgtid;
        logic [RN_ID_W-1:0]   id;
        logic [RN_LEN_W-1:0]  len;
    } trk_entry_t;

    // Target node is the top NODE_W address bits.
    function automatic logic [RN_NODE_W-1:0] sam_tgtid(input logic [RN_ADDR_W-1:0] addr);
        return addr[RN_ADDR_W-1 -: RN_NODE_W];
    endfunction

endpackage

// File: rtl/rn_axi_noc_bridge_aw_tracker.sv
// In-order FIFO of accepted AW requests; the head entry steers and frames
// the W beats of the oldest outstanding write burst.
module rn_aw_tracker
    import rn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  trk_entry_t i_push_data,
    input  logic       i_pop,
    output trk_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    trk_entry_t       r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Entry storage; contents are don't-care while the slot is not live.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
    end

    // Wrap-bit pointers distinguish full from empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/rn_axi_noc_bridge.sv
// Request-node bridge: CPU AXI4 master onto the five NoC channels, with an
// AW tracker for W steering/framing, outstanding limits and WLAST checking.
module rn_axi_noc_bridge
    import rn_pkg::*;
#(
    parameter int ID_W      = RN_ID_W,
    parameter int ADDR_W    = RN_ADDR_W,
    parameter int DATA_W    = RN_DATA_W,
    parameter int NODE_W    = RN_NODE_W,
    parameter int PLD_W     = RN_PLD_W,
    parameter int TRK_DEPTH = 4,
    parameter int MAX_WR    = 8,
    parameter int MAX_RD    = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [ID_W-1:0]     i_awid,
    input  logic [ADDR_W-1:0]   i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_wvalid,
    output logic                o_wready,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic                i_wlast,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [ID_W-1:0]     o_bid,
    output logic [1:0]          o_bresp,
    input  logic                i_arvalid,
    output logic                o_arready,
    input  logic [ID_W-1:0]     i_arid,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic [ID_W-1:0]     o_rid,
    output logic [DATA_W-1:0]   o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_aw_valid,
    input  logic                i_aw_ready,
    output logic [PLD_W-1:0]    o_aw_payload,
    output logic [NODE_W-1:0]   o_aw_tgtid,
    output logic                o_w_valid,
    input  logic                i_w_ready,
    output logic                o_w_head,
    output logic                o_w_tail,
    output logic [PLD_W-1:0]    o_w_payload,
    output logic [NODE_W-1:0]   o_w_tgtid,
    input  logic                i_b_valid,
    output logic                o_b_ready,
    input  logic [19:0]         i_b_payload,
    output logic                o_ar_valid,
    input  logic                i_ar_ready,
    output logic [PLD_W-1:0]    o_ar_payload,
    output logic [NODE_W-1:0]   o_ar_tgtid,
    input  logic                i_r_valid,
    output logic                o_r_ready,
    input  logic                i_r_tail,
    input  logic [PLD_W-1:0]    i_r_payload,
    output logic                o_err_wlast
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int WID_BITS = PLD_W - DATA_W - STRB_W;
    localparam int WCNT_W   = $clog2(MAX_WR + 1);
    localparam int RCNT_W   = $clog2(MAX_RD + 1);

    function automatic logic [PLD_W-1:0] pack_req(input logic [ID_W-1:0] id,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
        logic [PLD_W-1:0] p;
        p = '0;
        p[OFS_ID +: ID_W]      = id;
        p[OFS_ADDR +: ADDR_W]  = addr;
        p[OFS_LEN +: 8]        = len;
        p[OFS_SIZE +: 3]       = size;
        p[OFS_BURST +: 2]      = burst;
        return p;
    endfunction

    logic [7:0]        r_beat_cnt;
    logic [WCNT_W-1:0] r_wr_cnt;
    logic [RCNT_W-1:0] r_rd_cnt;
    logic              r_err_wlast;

    trk_entry_t w_push_entry;
    trk_entry_t w_head_entry;
    logic       w_trk_full;
    logic       w_trk_empty;
    logic       w_aw_ok;
    logic       w_ar_ok;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_b_hs;
    logic       w_ar_hs;
    logic       w_r_last_hs;
    logic       w_tail;
    logic       w_unused;

    // Admission only looks at registered state, so a same-cycle pop or B never opens the gate.
    assign w_aw_ok = ~w_trk_full && (r_wr_cnt < WCNT_W'(MAX_WR));
    assign w_ar_ok = (r_rd_cnt < RCNT_W'(MAX_RD));

    assign o_aw_valid   = i_awvalid & w_aw_ok;
    assign o_awready    = i_aw_ready & w_aw_ok;
    assign o_aw_tgtid   = sam_tgtid(i_awaddr);
    assign o_aw_payload = pack_req(i_awid, i_awaddr, i_awlen, i_awsize, i_awburst);
    assign w_aw_hs      = i_awvalid & i_aw_ready & w_aw_ok;

    assign w_push_entry = '{tgtid: sam_tgtid(i_awaddr), id: i_awid, len: i_awlen};

    rn_aw_tracker #(
        .DEPTH (TRK_DEPTH)
    ) u_aw_tracker (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_aw_hs),
        .i_push_data (w_push_entry),
        .i_pop       (w_w_hs & w_tail),
        .o_head      (w_head_entry),
        .o_full      (w_trk_full),
        .o_empty     (w_trk_empty)
    );

    // W framing comes from the tracked AWLEN, never from WLAST.
    assign w_tail      = (r_beat_cnt == w_head_entry.len);
    assign o_w_valid   = i_wvalid & ~w_trk_empty;
    assign o_wready    = i_w_ready & ~w_trk_empty;
    assign o_w_head    = (r_beat_cnt == 8'd0);
    assign o_w_tail    = w_tail;
    assign o_w_tgtid   = w_head_entry.tgtid;
    assign o_w_payload = {i_wstrb, i_wdata, w_head_entry.id[WID_BITS-1:0]};
    assign w_w_hs      = i_wvalid & i_w_ready & ~w_trk_empty;

    assign o_ar_valid   = i_arvalid & w_ar_ok;
    assign o_arready    = i_ar_ready & w_ar_ok;
    assign o_ar_tgtid   = sam_tgtid(i_araddr);
    assign o_ar_payload = pack_req(i_arid, i_araddr, i_arlen, i_arsize, i_arburst);
    assign w_ar_hs      = i_arvalid & i_ar_ready & w_ar_ok;

    assign o_bvalid  = i_b_valid;
    assign o_b_ready = i_bready;
    assign o_bid     = i_b_payload[ID_W-1:0];
    assign o_bresp   = i_b_payload[ID_W +: 2];
    assign w_b_hs    = i_b_valid & i_bready;

    assign o_rvalid    = i_r_valid;
    assign o_r_ready   = i_rready;
    assign o_rlast     = i_r_tail;
    assign o_rid       = i_r_payload[ID_W-1:0];
    assign o_rdata     = i_r_payload[ID_W +: DATA_W];
    assign o_rresp     = i_r_payload[ID_W+DATA_W +: 2];
    assign w_r_last_hs = i_r_valid & i_rready & i_r_tail;

    assign o_err_wlast = r_err_wlast;

    assign w_unused = ^{i_b_payload[19:ID_W+2], i_r_payload[PLD_W-1:ID_W+DATA_W+2],
                        w_head_entry.id[ID_W-1:WID_BITS]};

    // Beat position within the head burst and sticky WLAST disagreement flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_beat_cnt  <= 8'd0;
            r_err_wlast <= 1'b0;
        end else if (w_w_hs) begin
            r_beat_cnt <= w_tail ? 8'd0 : r_beat_cnt + 8'd1;
            if (i_wlast != w_tail) r_err_wlast <= 1'b1;
        end
    end

    // Outstanding write/read counters; an unmatched decrement at zero saturates.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_aw_hs && !w_b_hs)
                r_wr_cnt <= r_wr_cnt + WCNT_W'(1);
            else if (!w_aw_hs && w_b_hs && r_wr_cnt != '0)
                r_wr_cnt <= r_wr_cnt - WCNT_W'(1);
            if (w_ar_hs && !w_r_last_hs)
                r_rd_cnt <= r_rd_cnt + RCNT_W'(1);
            else if (!w_ar_hs && w_r_last_hs && r_rd_cnt != '0)
                r_rd_cnt <= r_rd_cnt - RCNT_W'(1);
        end
    end

    a_wr_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_b_hs && !w_aw_hs && r_wr_cnt == '0));
    a_rd_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_r_last_hs && !w_ar_hs && r_rd_cnt == '0));

endmodule
